// File: rtl/bp_me_mem_arbiter_2to1_pkg.sv
// Shared types for the two-requester memory arbiter.
package bp_me_mem_arbiter_2to1_pkg;

    // Identifies which requester issued a command. These values are also the tags held in the order FIFO.
    typedef enum logic {
        e_arb_port0 = 1'b0,
        e_arb_port1 = 1'b1
    } bp_mem_arb_port_e;

endpackage

// File: rtl/bp_me_mem_arbiter_2to1_tag_fifo.sv
// Small register-based FIFO that holds one tag per in-flight command.
module bp_me_mem_arbiter_2to1_tag_fifo #(
    parameter int unsigned width_p = 1,
    parameter int unsigned els_p   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [width_p-1:0] wdata,
    input  logic               pop,
    output logic [width_p-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PtrW = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned CntW = $clog2(els_p + 1);

    logic [width_p-1:0] mem_r [els_p];
    logic [PtrW-1:0]    rptr_r, wptr_r;
    logic [CntW-1:0]    count_r;
    logic               do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_r == CntW'(els_p));
    assign empty   = (count_r == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_r[rptr_r];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_push) wptr_r <= ptr_inc(wptr_r);
            if (do_pop)  rptr_r <= ptr_inc(rptr_r);
            count_r <= count_r + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Storage needs no reset because occupancy is tracked by count_r.
    always_ff @(posedge clk) begin
        if (do_push) mem_r[wptr_r] <= wdata;
    end

endmodule

// File: rtl/bp_me_mem_arbiter_2to1.sv
// Two-to-one memory port arbiter: round-robin on commands, in-order response routing.
module bp_me_mem_arbiter_2to1
    import bp_me_mem_arbiter_2to1_pkg::*;
#(
    parameter int unsigned mem_msg_width_p   = 128,
    parameter int unsigned outstanding_els_p = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic [mem_msg_width_p-1:0] cmd0_i,
    input  logic                       cmd0_v_i,
    output logic                       cmd0_ready_o,
    input  logic [mem_msg_width_p-1:0] cmd1_i,
    input  logic                       cmd1_v_i,
    output logic                       cmd1_ready_o,

    output logic [mem_msg_width_p-1:0] resp0_o,
    output logic                       resp0_v_o,
    input  logic                       resp0_yumi_i,
    output logic [mem_msg_width_p-1:0] resp1_o,
    output logic                       resp1_v_o,
    input  logic                       resp1_yumi_i,

    output logic [mem_msg_width_p-1:0] mem_cmd_o,
    output logic                       mem_cmd_v_o,
    input  logic                       mem_cmd_ready_i,
    input  logic [mem_msg_width_p-1:0] mem_resp_i,
    input  logic                       mem_resp_v_i,
    output logic                       mem_resp_yumi_o
);

    bp_mem_arb_port_e last_grant_r, grant, head;
    logic             reset_r;
    logic             active;
    logic             fifo_full, fifo_empty;
    logic             fire;
    logic             grant_bit, head_bit;
    logic             resp_ok;

    // Handshakes stay quiet during reset and for one cycle after it.
    assign active = ~(reset_i | reset_r);

    // Round-robin: on contention the port not served last wins, otherwise the lone valid port.
    always_comb begin
        grant = e_arb_port0;
        if (cmd0_v_i & cmd1_v_i) begin
            grant = (last_grant_r == e_arb_port0) ? e_arb_port1 : e_arb_port0;
        end else if (cmd1_v_i) begin
            grant = e_arb_port1;
        end
    end

    assign mem_cmd_o    = (grant == e_arb_port1) ? cmd1_i : cmd0_i;
    assign mem_cmd_v_o  = active & (cmd0_v_i | cmd1_v_i) & ~fifo_full;
    assign fire         = mem_cmd_v_o & mem_cmd_ready_i;
    assign cmd0_ready_o = fire & (grant == e_arb_port0);
    assign cmd1_ready_o = fire & (grant == e_arb_port1);

    assign grant_bit = grant;
    assign head      = bp_mem_arb_port_e'(head_bit);

    assign resp_ok         = active & mem_resp_v_i & ~fifo_empty;
    assign resp0_o         = mem_resp_i;
    assign resp1_o         = mem_resp_i;
    assign resp0_v_o       = resp_ok & (head == e_arb_port0);
    assign resp1_v_o       = resp_ok & (head == e_arb_port1);
    assign mem_resp_yumi_o = (resp0_v_o & resp0_yumi_i) | (resp1_v_o & resp1_yumi_i);

    // Track reset history and remember the last port that issued a command.
    always_ff @(posedge clk_i) begin
        reset_r <= reset_i;
        if (reset_i) begin
            last_grant_r <= e_arb_port1;
        end else if (fire) begin
            last_grant_r <= grant;
        end
    end

    bp_me_mem_arbiter_2to1_tag_fifo #(
        .width_p(1),
        .els_p  (outstanding_els_p)
    ) u_tag_fifo (
        .clk  (clk_i),
        .reset(reset_i),
        .push (fire),
        .wdata(grant_bit),
        .pop  (mem_resp_yumi_o),
        .rdata(head_bit),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // A response with nothing outstanding means memory broke the protocol.
    resp_without_cmd_a: assert property (
        @(posedge clk_i) disable iff (reset_i || reset_r) !(mem_resp_v_i && fifo_empty)
    );

endmodule
